// File: rtl/sistema_lut_pkg.sv
// Shared definitions for the sistema_lut block.
// Holds the control FSM state encoding and the default sizing constants
// used by the top level and its bench.
package sistema_lut_pkg;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int N_IN_DEF  = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sistema_lut_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
// Ports:
//   CLK    - clock, rising edge
//   RST_N  - asynchronous active-low reset, forces the count to 0
//   i_clr  - synchronous clear, has priority over i_inc
//   i_inc  - add one this cycle unless already at the maximum value
//   o_cnt  - current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = &r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sistema_lut.sv
// Serially configurable N_IN-input lookup table with a registered output
// and a saturating count of results equal to 1.
// Ports:
//   CLK, RST_N            - clock and asynchronous active-low reset
//   CFG_START             - pulse: (re)start a truth-table load at entry 0
//   CFG_VALID, CFG_BIT    - serial table bits, entry 0 first
//   CFG_DONE              - high while a complete table is loaded (RUN)
//   IN_VALID, IN          - lookup request; IN[N_IN-1] is input A
//   Q, Q_VALID            - registered lookup result, one cycle latency
//   CNT_CLR               - synchronous clear of ONES_CNT
//   ONES_CNT              - number of valid results with Q=1 (saturating)
module sistema_lut
  import sistema_lut_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CFG_START,
  input  logic             CFG_VALID,
  input  logic             CFG_BIT,
  output logic             CFG_DONE,
  input  logic             IN_VALID,
  input  logic [N_IN-1:0]  IN,
  output logic             Q,
  output logic             Q_VALID,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] ONES_CNT
);

  localparam int DEPTH = 1 << N_IN;

  state_t            r_state;
  logic [DEPTH-1:0]  r_table;
  logic [N_IN-1:0]   r_idx;
  logic              r_q;
  logic              r_q_valid;
  logic              r_cfg_done;
  logic              w_last_bit;

  assign w_last_bit = (r_idx == N_IN'(DEPTH - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_UNCFG;
      r_table    <= '0;
      r_idx      <= '0;
      r_q        <= 1'b0;
      r_q_valid  <= 1'b0;
      r_cfg_done <= 1'b0;
    end else begin
      r_q_valid <= 1'b0;
      // CFG_START outranks everything, including a coincident CFG_VALID bit.
      if (CFG_START) begin
        r_state    <= ST_LOAD;
        r_idx      <= '0;
        r_cfg_done <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (CFG_VALID) begin
              r_table[r_idx] <= CFG_BIT;
              r_idx          <= r_idx + 1'b1;
              if (w_last_bit) begin
                r_state    <= ST_RUN;
                r_cfg_done <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (IN_VALID) begin
              r_q       <= r_table[IN];
              r_q_valid <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_UNCFG;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_ones_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_clr (CNT_CLR),
    .i_inc (r_q_valid & r_q),
    .o_cnt (ONES_CNT)
  );

  assign CFG_DONE = r_cfg_done;
  assign Q        = r_q;
  assign Q_VALID  = r_q_valid;

endmodule

// File: tb/tb_sistema_lut.sv
module tb_sistema_lut;
  import sistema_lut_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start, cfg_valid, cfg_bit;
  logic       in_valid;
  logic [3:0] in_v;
  logic       cnt_clr;

  logic       done8, q8, qv8;
  logic [7:0] cnt8;
  logic       done2, q2, qv2;
  logic [1:0] cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sistema_lut #(.N_IN(4), .CNT_W(8)) u_dut (
    .CLK(clk), .RST_N(rst_n), .CFG_START(cfg_start), .CFG_VALID(cfg_valid),
    .CFG_BIT(cfg_bit), .CFG_DONE(done8), .IN_VALID(in_valid), .IN(in_v),
    .Q(q8), .Q_VALID(qv8), .CNT_CLR(cnt_clr), .ONES_CNT(cnt8)
  );

  sistema_lut #(.N_IN(4), .CNT_W(2)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .CFG_START(cfg_start), .CFG_VALID(cfg_valid),
    .CFG_BIT(cfg_bit), .CFG_DONE(done2), .IN_VALID(in_valid), .IN(in_v),
    .Q(q2), .Q_VALID(qv2), .CNT_CLR(cnt_clr), .ONES_CNT(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Feed 'nbits' entries of 'tbl' starting at entry 0; optional stall cycles.
  task automatic feed_bits(input logic [15:0] tbl, input int nbits, input bit gaps);
    logic [15:0] t;
    t = tbl;
    for (int i = 0; i < nbits; i++) begin
      if (gaps && (i % 3 == 1)) begin
        cfg_valid = 1'b0;
        tick();
        check("done_low_during_gap", {31'd0, done8}, 32'd0);
        check("qv_low_in_load", {31'd0, qv8}, 32'd0);
      end
      cfg_valid = 1'b1;
      cfg_bit   = t[i];
      tick();
      if (i < 15) check("done_low_before_16th", {31'd0, done8}, 32'd0);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] tbl);
    start_pulse();
    feed_bits(tbl, 16, 1'b0);
    check("done_after_load", {31'd0, done8}, 32'd1);
  endtask

  task automatic lookup(input logic [3:0] v);
    in_valid = 1'b1;
    in_v     = v;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic clear_cnt();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_v = '0; cnt_clr = 1'b0;
    #12;
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_q", {31'd0, q8}, 32'd0);
    check("rst_qv", {31'd0, qv8}, 32'd0);
    check("rst_cnt", {24'd0, cnt8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // UNCFG ignores IN_VALID and CFG_VALID
    in_valid = 1'b1; in_v = 4'hF; cfg_valid = 1'b1; cfg_bit = 1'b1;
    tick();
    check("uncfg_qv", {31'd0, qv8}, 32'd0);
    check("uncfg_done", {31'd0, done8}, 32'd0);
    in_valid = 1'b0; cfg_valid = 1'b0;

    // Single-minterm table 16'h8000
    load(16'h8000);
    lookup(4'hF);
    check("and_q_F", {31'd0, q8}, 32'd1);
    check("and_qv_F", {31'd0, qv8}, 32'd1);
    lookup(4'h7);
    check("and_q_7", {31'd0, q8}, 32'd0);
    check("and_qv_7", {31'd0, qv8}, 32'd1);
    idle();
    check("and_qv_idle", {31'd0, qv8}, 32'd0);
    check("and_cnt", {24'd0, cnt8}, 32'd1);
    // CFG_VALID in RUN must not disturb the table
    cfg_valid = 1'b1; cfg_bit = 1'b0;
    tick(); tick();
    cfg_valid = 1'b0;
    lookup(4'hF);
    check("run_ignores_cfg", {31'd0, q8}, 32'd1);
    idle();
    check("q_hold_idle", {31'd0, q8}, 32'd1);
    check("cnt_after_second_one", {24'd0, cnt8}, 32'd2);
    clear_cnt();
    check("cnt_clr", {24'd0, cnt8}, 32'd0);

    // Parity table, back-to-back sweep
    load(16'h6996);
    for (int i = 0; i < 16; i++) begin
      lookup(4'(i));
      check("parity_q", {31'd0, q8}, {31'd0, ^4'(i)});
      check("parity_qv", {31'd0, qv8}, 32'd1);
    end
    idle();
    check("parity_cnt", {24'd0, cnt8}, 32'd8);
    check("parity_cnt_sat2", {30'd0, cnt2}, 32'd3);
    // reload preserves the count
    start_pulse();
    check("cnt_kept_on_reload", {24'd0, cnt8}, 32'd8);
    check("done_low_on_start", {31'd0, done8}, 32'd0);

    // Load with stalls while IN_VALID is asserted
    in_valid = 1'b1; in_v = 4'hF;
    feed_bits(16'h8000, 16, 1'b1);
    check("gap_done", {31'd0, done8}, 32'd1);
    check("gap_qv_load", {31'd0, qv8}, 32'd0);
    lookup(4'hF);
    check("gap_q", {31'd0, q8}, 32'd1);
    idle();

    // Aborted load, START coinciding with a valid bit, then reload 16'h0001
    start_pulse();
    feed_bits(16'hFFFF, 7, 1'b0);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    feed_bits(16'h0001, 15, 1'b0);
    check("abort_done_at_15", {31'd0, done8}, 32'd0);
    cfg_valid = 1'b1; cfg_bit = 1'b0;
    tick();
    cfg_valid = 1'b0;
    check("abort_done_at_16", {31'd0, done8}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      lookup(4'(i));
      check("min0_q", {31'd0, q8}, (i == 0) ? 32'd1 : 32'd0);
    end
    idle();

    // Saturation on CNT_W=2 instance with an all-ones table
    clear_cnt();
    check("sat_clr", {30'd0, cnt2}, 32'd0);
    load(16'hFFFF);
    lookup(4'h3);
    for (int k = 1; k <= 6; k++) begin
      if (k < 6) lookup(4'(k)); else idle();
      check("sat_seq", {30'd0, cnt2}, (k < 3) ? k : 3);
    end
    check("wide_cnt_6", {24'd0, cnt8}, 32'd6);
    lookup(4'h9);
    check("clr_prio_qv", {31'd0, qv2 & q2}, 32'd1);
    clear_cnt();
    check("clr_prio_cnt2", {30'd0, cnt2}, 32'd0);
    check("clr_prio_cnt8", {24'd0, cnt8}, 32'd0);

    // Asynchronous reset in the middle of RUN
    lookup(4'h1);
    lookup(4'h2);
    rst_n = 1'b0;
    #1;
    check("arst_done", {31'd0, done8}, 32'd0);
    check("arst_qv", {31'd0, qv8}, 32'd0);
    check("arst_q", {31'd0, q8}, 32'd0);
    check("arst_cnt", {24'd0, cnt8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lookup(4'h5);
    lookup(4'h6);
    check("post_rst_qv", {31'd0, qv8}, 32'd0);
    check("post_rst_done", {31'd0, done8}, 32'd0);
    idle();
    check("post_rst_cnt", {24'd0, cnt8}, 32'd0);
    // table must be discarded: a fresh load of zeros gives Q=0 everywhere
    load(16'h0000);
    lookup(4'hF);
    check("post_rst_reload_q", {31'd0, q8}, 32'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sistema_lut.md
SISTEMA_LUT -- requirements
Module: sistema_lut

Interface
REQ-001 The module SHALL have parameter N_IN, default 4, number of boolean inputs (legal 2..6).
REQ-002 The module SHALL have parameter CNT_W, default 8, width of the ones-event counter.
REQ-003 The module SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 The module SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port CFG_START  input  1  one-cycle pulse that begins a truth-table load.
REQ-006 The module SHALL have port CFG_VALID  input  1  CFG_BIT is valid this cycle.
REQ-007 The module SHALL have port CFG_BIT  input  1  serial truth-table bit, LSB (entry 0) first.
REQ-008 The module SHALL have port CFG_DONE  output  1  high while the state is RUN.
REQ-009 The module SHALL have port IN_VALID  input  1  IN is valid this cycle.
REQ-010 The module SHALL have port IN  input  N_IN  input vector; IN[N_IN-1] corresponds to A, IN[0] to the last input.
REQ-011 The module SHALL have port Q  output  1  registered function output.
REQ-012 The module SHALL have port Q_VALID  output  1  Q holds a fresh result.
REQ-013 The module SHALL have port CNT_CLR  input  1  synchronous clear of ONES_CNT.
REQ-014 The module SHALL have port ONES_CNT  output  CNT_W  count of valid results with Q=1.

Function
REQ-015 The FSM SHALL have the states UNCFG, LOAD and RUN, with reset state UNCFG.
REQ-016 CFG_START in any state SHALL move the FSM to LOAD, zero the bit index and clear Q_VALID on the next cycle.
REQ-017 In LOAD, each cycle with CFG_VALID=1 SHALL write TABLE[idx]=CFG_BIT and increment idx; cycles with CFG_VALID=0 SHALL be stalls.
REQ-018 When the 2^N_IN-th bit is accepted, the FSM SHALL enter RUN on the following cycle; CFG_DONE SHALL be high from that cycle onward.
REQ-019 CFG_VALID outside LOAD SHALL be ignored; when CFG_START and CFG_VALID coincide, CFG_START SHALL win and the bit SHALL be discarded.
REQ-020 In RUN, IN_VALID=1 at edge k SHALL produce Q=TABLE[IN] and Q_VALID=1 after edge k (1-cycle latency).
REQ-021 IN_VALID=0 in RUN SHALL give Q_VALID=0 with Q holding its last value.
REQ-022 IN_VALID in UNCFG or LOAD SHALL be ignored; Q_VALID=0 in those states.
REQ-023 Each cycle with Q_VALID=1 and Q=1 SHALL increment ONES_CNT by one, saturating at 2^CNT_W-1 (no wrap).
REQ-024 When CNT_CLR and an increment coincide, CNT_CLR SHALL win and ONES_CNT SHALL become 0.
REQ-025 ONES_CNT SHALL be preserved across reloads (CFG_START); only reset or CNT_CLR SHALL clear it.
REQ-026 A reload SHALL overwrite every TABLE entry; an aborted load (CFG_START again mid-LOAD) SHALL restart at idx 0.

Reset
REQ-027 RST_N low SHALL asynchronously force: state UNCFG, TABLE all 0, idx 0, Q=0, Q_VALID=0, CFG_DONE=0, ONES_CNT=0.
REQ-028 Reset asserted mid-LOAD or mid-RUN SHALL discard the table, and the block SHALL return to UNCFG with no output activity until a full reload.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (UNCFG, LOAD, RUN) and the N_IN and CNT_W default constants.
REQ-030 The saturating counter with clear priority SHALL be a sub-module, sat_counter, parametrised by CNT_W.
REQ-031 TABLE SHALL be a 2^N_IN-bit register; no memory macro SHALL be used.

Verification (N_IN=4 unless stated)
REQ-032 Load 16'h8000, then IN=4'hF then 4'h7 with IN_VALID -> Q=1 then Q=0, each one cycle later; ONES_CNT=1.
REQ-033 Load 16'h6996 (parity), sweep IN 0..15 back-to-back -> Q equals XOR of IN bits every cycle; ONES_CNT=8.
REQ-034 CFG_VALID toggled with gaps during load -> CFG_DONE rises only after the 16th accepted bit; IN_VALID during LOAD -> Q_VALID stays 0.
REQ-035 CNT_W=2, table all ones, 6 valid inputs -> ONES_CNT sequence 1,2,3,3,3,3; CNT_CLR with a valid Q=1 -> ONES_CNT=0.
REQ-036 CFG_START after 7 bits of a load, then a full reload of 16'h0001 -> only IN=0 gives Q=1; RST_N pulsed mid-RUN -> CFG_DONE=0, Q_VALID=0, ONES_CNT=0 immediately.
